// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Mult/div run for a fixed number of busy cycles; mthi/mtlo write HI/LO directly.
module mdu #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [1:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;

  logic          w_accept;
  logic          w_launch;
  logic          w_finish;
  logic [63:0]   w_sprod;
  logic [63:0]   w_uprod;
  logic          w_signed;
  logic [31:0]   w_dvd;
  logic [31:0]   w_dvs;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic [31:0]   w_quo;
  logic [31:0]   w_rem;
  logic          w_divZero;

  assign w_accept = start && (r_state == IDLE);
  assign w_launch = w_accept && !op[2];
  assign w_finish = (r_state == RUN) && (r_count == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_next = RUN;
      RUN:     if (w_finish) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
  end

  // Operands are frozen at the accepting edge so later input changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_launch) begin
      r_count <= op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
      r_op    <= op[1:0];
      r_a     <= DataA;
      r_b     <= DataB;
    end else if (r_state == RUN) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign w_sprod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_uprod = {32'b0, r_a} * {32'b0, r_b};

  // Signed divide goes through magnitudes, which also yields 0x80000000 / -1 = 0x80000000.
  assign w_signed  = !r_op[0];
  assign w_divZero = (r_b == 32'b0);
  assign w_dvd     = (w_signed && r_a[31]) ? -r_a : r_a;
  assign w_dvs     = w_divZero ? 32'd1 : ((w_signed && r_b[31]) ? -r_b : r_b);
  assign w_uq      = w_dvd / w_dvs;
  assign w_ur      = w_dvd % w_dvs;
  assign w_quo     = (w_signed && (r_a[31] ^ r_b[31])) ? -w_uq : w_uq;
  assign w_rem     = (w_signed && r_a[31]) ? -w_ur : w_ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (w_accept && (op == 3'd4)) begin
      HI <= DataA;
    end else if (w_accept && (op == 3'd5)) begin
      LO <= DataA;
    end else if (w_finish) begin
      case (r_op)
        2'd0:    {HI, LO} <= w_sprod;
        2'd1:    {HI, LO} <= w_uprod;
        default: if (!w_divZero) {HI, LO} <= {w_rem, w_quo};
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu: an arithmetic reference model tracks HI/LO/busy,
// and directed cases pin the model against hand-computed values.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  int          mLeft = 0;
  bit          pendWr = 0;
  logic [31:0] pendHi = '0;
  logic [31:0] pendLo = '0;

  mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .DataA (DataA),
    .DataB (DataB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definitions, using 64-bit math.
  function automatic void refOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output bit wr, output logic [31:0] hi, output logic [31:0] lo);
    longint sa;
    longint sb;
    longint sq;
    longint sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    hi = '0;
    lo = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 32'b0) wr = 1'b0;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          lo = sq[31:0];
          hi = sr[31:0];
        end
      end
      3'd3: begin
        if (b == 32'b0) wr = 1'b0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit          w;
    logic [31:0] h;
    logic [31:0] l;
    if (!reset) begin
      mHi    <= '0;
      mLo    <= '0;
      mLeft  <= 0;
      pendWr <= 1'b0;
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1 && pendWr) begin
        mHi <= pendHi;
        mLo <= pendLo;
      end
    end else if (start) begin
      if (op == 3'd4) mHi <= DataA;
      else if (op == 3'd5) mLo <= DataA;
      else if (op < 3'd4) begin
        refOp(op, DataA, DataB, w, h, l);
        pendWr <= w;
        pendHi <= h;
        pendLo <= l;
        mLeft  <= op[1] ? 10 : 5;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, mLeft != 0});
      checkOutput("HI", HI, mHi);
      checkOutput("LO", LO, mLo);
    end
  end

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = s;
    op    = o;
    DataA = a;
    DataB = b;
  endtask

  task automatic issueOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, o, a, b);
    applyStimulus(1'b0, o, a, b);
  endtask

  task automatic waitIdle(input bit noise, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (noise) applyStimulus(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      else       applyStimulus(1'b0, 3'd7, DataA, DataB);
    end
    start = 1'b0;
    checkOutput("idleTimeout", {31'b0, cyc >= 64}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    DataA = '0;
    DataB = '0;
    #1 reset = 1'b0;
    #1 checkEn = 1'b1;
    #1;
    checkOutput("resetBusy", {31'b0, busy}, 32'd0);
    checkOutput("resetHI", HI, 32'd0);
    checkOutput("resetLO", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // mult -2*3 with operand changes and extra starts while busy
    issueOp(3'd0, 32'hFFFFFFFE, 32'd3);
    waitIdle(1'b1, cyc);
    checkOutput("multCycles", cyc, 32'd5);
    checkOutput("multHI", HI, 32'hFFFFFFFF);
    checkOutput("multLO", LO, 32'hFFFFFFFA);

    issueOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle(1'b0, cyc);
    checkOutput("multuCycles", cyc, 32'd5);
    checkOutput("multuHI", HI, 32'hFFFFFFFE);
    checkOutput("multuLO", LO, 32'h00000001);

    issueOp(3'd2, 32'hFFFFFFF9, 32'd2);
    waitIdle(1'b0, cyc);
    checkOutput("divCycles", cyc, 32'd10);
    checkOutput("divHI", HI, 32'hFFFFFFFF);
    checkOutput("divLO", LO, 32'hFFFFFFFD);

    issueOp(3'd4, 32'h11, 32'd0);
    checkOutput("mthiHI", HI, 32'h11);
    checkOutput("mthiBusy", {31'b0, busy}, 32'd0);
    issueOp(3'd5, 32'h22, 32'd0);
    checkOutput("mtloLO", LO, 32'h22);
    checkOutput("mtloKeepHI", HI, 32'h11);
    issueOp(3'd3, 32'd7, 32'd0);
    waitIdle(1'b0, cyc);
    checkOutput("div0Cycles", cyc, 32'd10);
    checkOutput("div0HI", HI, 32'h11);
    checkOutput("div0LO", LO, 32'h22);

    issueOp(3'd4, 32'hDEADBEEF, 32'd0);
    checkOutput("mthiDeadHI", HI, 32'hDEADBEEF);
    checkOutput("mthiDeadLO", LO, 32'h22);
    checkOutput("mthiDeadBusy", {31'b0, busy}, 32'd0);

    issueOp(3'd6, 32'h5555AAAA, 32'd1);
    checkOutput("nopHI", HI, 32'hDEADBEEF);
    checkOutput("nopLO", LO, 32'h22);
    checkOutput("nopBusy", {31'b0, busy}, 32'd0);

    issueOp(3'd2, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(1'b0, cyc);
    checkOutput("divOvfHI", HI, 32'h0);
    checkOutput("divOvfLO", LO, 32'h80000000);

    // mtlo while running is dropped, and the next op follows after one idle cycle
    issueOp(3'd0, 32'd2, 32'd3);
    applyStimulus(1'b1, 3'd5, 32'h12345678, 32'd0);
    applyStimulus(1'b0, 3'd5, 32'h12345678, 32'd0);
    waitIdle(1'b0, cyc);
    checkOutput("mtloRunCycles", cyc, 32'd3);
    checkOutput("mtloRunLO", LO, 32'd6);
    checkOutput("mtloRunHI", HI, 32'd0);
    issueOp(3'd1, 32'h10, 32'h10);
    checkOutput("b2bBusy", {31'b0, busy}, 32'd1);
    waitIdle(1'b0, cyc);
    checkOutput("b2bCycles", cyc, 32'd5);
    checkOutput("b2bLO", LO, 32'h100);

    // reset in the third busy cycle of a div
    issueOp(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'b0, busy}, 32'd0);
    checkOutput("midResetHI", HI, 32'd0);
    checkOutput("midResetLO", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    op    = 3'd4;
    DataA = 32'h0000CAFE;
    @(negedge clk);
    start = 1'b0;
    checkOutput("postResetHI", HI, 32'h0000CAFE);
    repeat (12) @(negedge clk);
    checkOutput("noLateWriteLO", LO, 32'd0);
    checkOutput("noLateWriteHI", HI, 32'h0000CAFE);

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      applyStimulus(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), ra, rb);
    end
    applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameters: MULT_CYC, default 5, number of busy cycles for mult/multu; DIV_CYC, default 10, number of busy cycles for div/divu.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to execute op.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
- DataA  input  32  operand A (dividend, multiplicand, mthi/mtlo source).
- DataB  input  32  operand B (divisor, multiplier).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register, registered.
- LO  output  32  LO register, registered.

Function
REQ-003 SHALL sample start, op, DataA and DataB only on rising edges where busy=0; start while busy=1 SHALL be ignored entirely.
REQ-004 SHALL implement two states, IDLE (busy=0) and RUN (busy=1), plus a down-counter of at least 4 bits.
REQ-005 IDLE->RUN on an accepted start with op 0-3: busy=1 from the next cycle; counter loaded with MULT_CYC or DIV_CYC.
REQ-006 RUN: counter decrements each edge. On the edge where counter reaches the final count, HI/LO SHALL update and busy SHALL drop together. busy is therefore high for exactly MULT_CYC or DIV_CYC consecutive cycles.
REQ-007 The result SHALL be computed from the operands captured at the accepting edge; later DataA/DataB changes SHALL have no effect.
REQ-008 HI/LO SHALL hold their old values throughout RUN; new values are visible only in the first cycle with busy=0.
REQ-009 mult: {HI,LO} = signed 32x32 -> 64-bit product, two's complement.
REQ-010 multu: {HI,LO} = unsigned 32x32 -> 64-bit product.
REQ-011 div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
REQ-012 div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-013 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-014 Divide by zero (DataB=0, op 2 or 3): SHALL still run DIV_CYC busy cycles, then leave HI and LO unchanged.
REQ-015 mthi/mtlo accepted in IDLE: HI (resp. LO) = DataA on the same edge; busy stays 0; the other register is unchanged.
REQ-016 op 6-7 with start SHALL change nothing.
REQ-017 start in the cycle busy falls is not accepted (busy=1 when sampled). Acceptance is possible from the following cycle, which allows back-to-back operations with one idle cycle.

Reset
REQ-018 reset low SHALL immediately and asynchronously force busy=0, HI=0, LO=0, counter=0, state=IDLE, regardless of clk.
REQ-019 Reset asserted mid-RUN SHALL abandon the operation; the pending result SHALL never be written.
REQ-020 After reset deassertion, the first rising edge SHALL accept start normally.

Verification
REQ-021 mult, A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-022 multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles: HI=0xFFFFFFFE, LO=0x00000001.
REQ-023 div, A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu, A=7, B=0 with HI=0x11, LO=0x22 beforehand -> after 10 cycles HI=0x11, LO=0x22.
REQ-024 mthi A=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle, busy stays 0. mtlo issued during RUN -> ignored, LO keeps its prior value.
REQ-025 Start mult, change DataA/DataB and pulse start during cycles 2-4 -> result uses the original operands; the extra starts are ignored.
REQ-026 Assert reset in RUN cycle 3 of a div -> busy, HI, LO read 0 before the next clk edge; no later write occurs.
